// File: rtl/hlsm_if1_sched.sv
// hlsm_if1_sched: a small scheduled datapath (one shared ALU, one comparator, one pipelined multiplier)
// that computes x = a*c - (a+b) and z = (a<b ? a+b : a+c) + a*c.
`default_nettype none

module hlsm_if1_sched #(
   parameter int MUL_LAT = 2
) (
   input  logic               Clk,
   input  logic               Rst,
   input  logic               Start,
   input  logic signed [31:0] a,
   input  logic signed [31:0] b,
   input  logic signed [31:0] c,
   output logic               Done,
   output logic               Busy,
   output logic signed [31:0] z,
   output logic signed [31:0] x
);

   typedef enum logic [2:0] {
      WAIT  = 3'd0,
      S1    = 3'd1,
      S2    = 3'd2,
      WAITM = 3'd3,
      S3    = 3'd4,
      S4    = 3'd5,
      FINAL = 3'd6
   } state_t;

   state_t             r_state, w_next;
   logic signed [31:0] r_a, r_b, r_c;
   logic signed [31:0] r_d, r_zrin, r_x, r_z;
   logic               r_g, r_done, r_busy;
   logic        [2:0]  r_wcnt;
   logic signed [31:0] r_mp [MUL_LAT];
   logic signed [31:0] w_prod, w_f;
   logic signed [31:0] w_alu_x, w_alu_y, w_alu;
   logic               w_alu_sub, w_lt;

   assign w_prod = r_a * r_c;
   assign w_f    = r_mp[MUL_LAT-1];
   assign w_lt   = (r_a < r_b);

   // The single ALU is steered by state; every state uses it at most once.
   always_comb begin
      w_alu_x   = '0;
      w_alu_y   = '0;
      w_alu_sub = 1'b0;
      case (r_state)
         S1: begin
            w_alu_x = r_a;
            w_alu_y = r_b;
         end
         S2: begin
            w_alu_x = r_a;
            w_alu_y = r_c;
         end
         S3: begin
            w_alu_x   = w_f;
            w_alu_y   = r_d;
            w_alu_sub = 1'b1;
         end
         S4: begin
            w_alu_x = r_zrin;
            w_alu_y = w_f;
         end
         default: ;
      endcase
   end

   assign w_alu = w_alu_sub ? (w_alu_x - w_alu_y) : (w_alu_x + w_alu_y);

   always_comb begin
      w_next = r_state;
      case (r_state)
         WAIT:    if (Start) w_next = S1;
         S1:      w_next = S2;
         S2:      w_next = (MUL_LAT <= 2) ? S3 : WAITM;
         // r_wcnt holds edges since issue minus one; leave once f lands at the next edge.
         WAITM:   if (r_wcnt >= 3'(MUL_LAT - 1)) w_next = S3;
         S3:      w_next = S4;
         S4:      w_next = FINAL;
         FINAL:   w_next = WAIT;
         default: w_next = WAIT;
      endcase
   end

   always_ff @(posedge Clk) begin
      if (Rst) begin
         r_state <= WAIT;
         r_a     <= '0;
         r_b     <= '0;
         r_c     <= '0;
         r_d     <= '0;
         r_g     <= 1'b0;
         r_zrin  <= '0;
         r_x     <= '0;
         r_z     <= '0;
         r_wcnt  <= '0;
         r_done  <= 1'b0;
         r_busy  <= 1'b0;
      end else begin
         r_state <= w_next;
         r_done  <= (w_next == FINAL);
         r_busy  <= (w_next != WAIT);
         case (r_state)
            WAIT: if (Start) begin
               r_a <= a;
               r_b <= b;
               r_c <= c;
            end
            S1: begin
               r_d    <= w_alu;
               r_g    <= w_lt;
               r_wcnt <= 3'd1;
            end
            S2: begin
               r_zrin <= r_g ? r_d : w_alu;
               r_wcnt <= r_wcnt + 3'd1;
            end
            WAITM: r_wcnt <= r_wcnt + 3'd1;
            S3:    r_x <= w_alu;
            S4:    r_z <= w_alu;
            default: ;
         endcase
      end
   end

   // Stage 0 loads only on issue, so the tail of the pipe holds f through S3 and S4.
   always_ff @(posedge Clk) begin
      if (Rst) begin
         for (int i = 0; i < MUL_LAT; i++) r_mp[i] <= '0;
      end else begin
         if (r_state == S1) r_mp[0] <= w_prod;
         for (int i = 1; i < MUL_LAT; i++) r_mp[i] <= r_mp[i-1];
      end
   end

   assign Done = r_done;
   assign Busy = r_busy;
   assign z    = r_z;
   assign x    = r_x;

endmodule

`default_nettype wire

// File: doc/hlsm_if1_sched.md
HLSM_IF1_SCHED -- requirements
Module: hlsm_if1_sched

Interface
REQ-001 The block SHALL have parameter MUL_LAT, default 2, giving the multiplier latency in clock cycles from operand issue to registered result; the legal range is 1..4.
REQ-002 Clk  input  1  the single clock; all state SHALL update on its rising edge.
REQ-003 Rst  input  1  synchronous, active-high reset, sampled on the rising edge of Clk.
REQ-004 Start  input  1  request to begin one computation; honoured only in state WAIT.
REQ-005 a, b, c  input  32 each  signed operands, captured when Start is accepted.
REQ-006 Done  output  1  registered; high for exactly one cycle when z and x hold the new results.
REQ-007 Busy  output  1  registered; high in every state except WAIT.
REQ-008 z, x  output  32 each  signed, registered results.

Function
REQ-009 The block SHALL compute, using one shared adder/subtractor (ALU), one signed comparator and one MUL_LAT-stage multiplier:
- d = a+b
- g = (a<b)
- zrin = g ? a+b : a+c
- f = a*c
- x = f-d
- z = zrin+f
REQ-010 All arithmetic SHALL be signed two's-complement, modulo 2^32; the multiply SHALL keep the low 32 bits of the product, and the comparison SHALL be signed.
REQ-011 The FSM states SHALL be WAIT, S1, S2, WAITM, S3, S4 and FINAL.
REQ-012 WAIT: when Start=1, latch a, b and c, then go to S1; otherwise stay in WAIT.
REQ-013 S1: ALU computes d, comparator computes g, multiplier is issued; then go to S2.
REQ-014 S2: if g=1, zrin <= d with the ALU unused; if g=0, the ALU computes zrin <= a+c; then go to WAITM.
REQ-015 WAITM: stay until f is valid, i.e. MUL_LAT edges after the S1 issue; it SHALL take zero cycles when MUL_LAT<=2.
REQ-016 S3: ALU computes x <= f-d; then go to S4.
REQ-017 S4: ALU computes z <= zrin+f; then go to FINAL.
REQ-018 FINAL: Done=1; unconditionally go to WAIT.
REQ-019 The ALU SHALL perform at most one operation per cycle.
REQ-020 Latency: with Start accepted at rising edge 0, Done SHALL be high during cycle 3+max(2,MUL_LAT), which is cycle 5 for the default MUL_LAT=2.
REQ-021 Start SHALL be ignored in every state other than WAIT, including FINAL; a back-to-back request SHALL be accepted no earlier than the cycle after FINAL.
REQ-022 Changes on a, b or c after acceptance SHALL NOT affect the result in progress.
REQ-023 x SHALL update only in S3 and z only in S4; both SHALL hold their values until the next computation overwrites them.
REQ-024 Done SHALL be low in every state except FINAL.

Reset
REQ-025 When Rst=1 at an edge, the block SHALL go to WAIT with Done=0, Busy=0, z=0, x=0, and clear all internal registers (d, g, zrin, f, latched operands, multiplier pipeline, wait counter).
REQ-026 Reset SHALL take priority over Start and over any in-progress state, including mid-multiply; no partial result SHALL later appear on z or x.
REQ-027 If Start=1 in the same cycle that Rst=1, the Start request SHALL be discarded.

Verification
REQ-028 Branch taken: a=3, b=5, c=2, one-cycle Start -> Done high in cycle 5; x=-2, z=14; Busy high in cycles 1-5.
REQ-029 Branch not taken: a=7, b=5, c=2 -> x=2, z=23.
REQ-030 Equal operands: a=4, b=4, c=-3 -> g=0; x=-20, z=-11.
REQ-031 Wrap-around: a=32'h7FFFFFFF, b=1, c=2 -> x=32'h7FFFFFFE, z=32'h7FFFFFFF.
REQ-032 Reset and ignored Start:
- Pulse Start again in cycle 2 -> no effect.
- Assert Rst in S3 -> next cycle Done=0, Busy=0, z=0, x=0.
- Start in WAIT after reset -> normal result.
REQ-033 MUL_LAT=4 build: REQ-028 stimulus -> WAITM occupies cycles 3-4, Done high in cycle 7, same z and x.
